// File: rtl/target_lut_writer_pkg.sv
// Shared types and defaults for the programmable PC-target / data-address lookup table.
// The table stores raw two's-complement offsets; consumers sign-extend.
package target_lut_writer_pkg;

  localparam int LUT_IDX_W   = 4;
  localparam int LUT_DATA_W  = 11;
  localparam int LUT_DEF_VAL = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } lut_state_t;

endpackage

// File: rtl/target_lut_writer_if.sv
// Load, runtime-write and lookup signals of the target LUT writer.
// master drives requests and lookups, slave is the table block.
interface target_lut_writer_if
  import target_lut_writer_pkg::*;
#(
  parameter int IDX_W  = LUT_IDX_W,
  parameter int DATA_W = LUT_DATA_W
);

  logic              Start;
  logic              LdValid;
  logic [DATA_W-1:0] LdData;
  logic              LdReady;
  logic              WrEn;
  logic [IDX_W-1:0]  WrIndex;
  logic [DATA_W-1:0] WrData;
  logic              WrErr;
  logic [IDX_W-1:0]  Index;
  logic [DATA_W-1:0] Out;
  logic              Busy;
  logic              Loaded;

  modport master (
    output Start, LdValid, LdData, WrEn, WrIndex, WrData, Index,
    input  LdReady, WrErr, Out, Busy, Loaded
  );

  modport slave (
    input  Start, LdValid, LdData, WrEn, WrIndex, WrData, Index,
    output LdReady, WrErr, Out, Busy, Loaded
  );

endinterface

// File: rtl/target_lut_writer_lut_regfile.sv
// 2**IDX_W x DATA_W register table: one synchronous write port, one combinational read port.
// Asynchronous reset returns every entry to DEF_VAL.
module lut_regfile #(
  parameter int                IDX_W   = 4,
  parameter int                DATA_W  = 11,
  parameter logic [DATA_W-1:0] DEF_VAL = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DEF_VAL;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // No write bypass: a same-cycle write becomes visible after the edge.
  assign rdata = mem[raddr];

endmodule

// File: rtl/target_lut_writer.sv
// Programmable target LUT: streams a full table in on Start, allows single-entry patches
// outside a load, and serves combinational lookups from the registered table.
module target_lut_writer
  import target_lut_writer_pkg::*;
#(
  parameter int                IDX_W   = LUT_IDX_W,
  parameter int                DATA_W  = LUT_DATA_W,
  parameter logic [DATA_W-1:0] DEF_VAL = DATA_W'(LUT_DEF_VAL)
) (
  input logic                  Clk,
  input logic                  Reset_n,
  target_lut_writer_if.slave   bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_LOAD = LOAD;
  localparam logic [1:0] S_DONE = DONE;

  localparam logic [IDX_W-1:0] CNT_LAST = {IDX_W{1'b1}};

  logic [1:0]        state;
  logic [IDX_W-1:0]  cnt;
  logic              wr_err_q;
  logic              in_load;
  logic              ld_hs;
  logic              wr_ok;
  logic              rf_we;
  logic [IDX_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata;

  assign in_load = (state == S_LOAD);

  // Start takes priority over a same-cycle load beat and blocks runtime writes.
  assign ld_hs = bus.LdValid && in_load && !bus.Start;
  assign wr_ok = bus.WrEn && !in_load && !bus.Start;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= bus.WrEn && !wr_ok;
      if (bus.Start) begin
        state <= S_LOAD;
        cnt   <= '0;
      end else if (ld_hs) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state <= S_DONE;
        end
      end
    end
  end

  // Load beats and runtime writes are mutually exclusive by state, so one write port suffices.
  assign rf_we    = ld_hs || wr_ok;
  assign rf_waddr = ld_hs ? cnt : bus.WrIndex;
  assign rf_wdata = ld_hs ? bus.LdData : bus.WrData;

  lut_regfile #(
    .IDX_W   (IDX_W),
    .DATA_W  (DATA_W),
    .DEF_VAL (DEF_VAL)
  ) u_regfile (
    .clk   (Clk),
    .rst_n (Reset_n),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .raddr (bus.Index),
    .rdata (rf_rdata)
  );

  assign bus.Out     = rf_rdata;
  assign bus.LdReady = in_load;
  assign bus.Busy    = in_load;
  assign bus.Loaded  = (state == S_DONE);
  assign bus.WrErr   = wr_err_q;

endmodule

// File: tb/tb_target_lut_writer.sv
// Directed bench for target_lut_writer: reset defaults, full and stalled loads,
// runtime writes and rejections, restart mid-load, and asynchronous reset mid-load.
module tb_target_lut_writer;

  logic Clk;
  logic Reset_n;

  int n_cmp;
  int n_err;

  target_lut_writer_if #(.IDX_W(4), .DATA_W(11)) bus ();

  target_lut_writer dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_entry(input string tag, input int idx, input logic [10:0] expv);
    bus.Index = 4'(idx);
    #1;
    chk(tag, 32'(bus.Out), 32'(expv));
  endtask

  function automatic logic [10:0] first_load_val(input int i);
    logic [10:0] v;
    if (i == 0)       v = 11'h68E;         // -370
    else if (i == 15) v = 11'h69B;         // -357
    else              v = 11'(i + 1);
    return v;
  endfunction

  initial begin
    int hs;
    int cyc;
    n_cmp = 0;
    n_err = 0;
    bus.Start   = 1'b0;
    bus.LdValid = 1'b0;
    bus.LdData  = '0;
    bus.WrEn    = 1'b0;
    bus.WrIndex = '0;
    bus.WrData  = '0;
    bus.Index   = '0;
    Reset_n     = 1'b0;

    // 1. Reset defaults
    tick();
    tick();
    Reset_n = 1'b1;
    tick();
    chk_entry("rst_out0", 0, 11'd1);
    chk_entry("rst_out15", 15, 11'd1);
    chk("rst_loaded", 32'(bus.Loaded), 32'd0);
    chk("rst_ldready", 32'(bus.LdReady), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_wrerr", 32'(bus.WrErr), 32'd0);

    // 2. Back-to-back full load
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    chk("ld1_ldready", 32'(bus.LdReady), 32'd1);
    chk("ld1_busy", 32'(bus.Busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      bus.LdValid = 1'b1;
      bus.LdData  = first_load_val(i);
      tick();
      if (i == 14) chk("ld1_loaded_early", 32'(bus.Loaded), 32'd0);
    end
    bus.LdValid = 1'b0;
    chk("ld1_loaded", 32'(bus.Loaded), 32'd1);
    chk("ld1_busy_done", 32'(bus.Busy), 32'd0);
    chk("ld1_ldready_done", 32'(bus.LdReady), 32'd0);
    chk_entry("ld1_out0", 0, 11'h68E);
    chk_entry("ld1_out15", 15, 11'h69B);
    chk_entry("ld1_out7", 7, 11'd8);

    // 3. Stalled load: LdValid every other cycle
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    chk("ld2_loaded_clr", 32'(bus.Loaded), 32'd0);
    hs = 0;
    cyc = 0;
    while (hs < 16 && cyc < 100) begin
      bus.LdValid = cyc[0];
      bus.LdData  = 11'(100 + hs);
      tick();
      if (cyc[0]) hs++;
      cyc++;
      if (hs < 16) chk("ld2_busy", 32'(bus.Busy), 32'd1);
    end
    bus.LdValid = 1'b0;
    chk("ld2_hs_count", 32'(hs), 32'd16);
    chk("ld2_loaded", 32'(bus.Loaded), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk_entry($sformatf("ld2_entry%0d", i), i, 11'(100 + i));
    end

    // 4. Runtime write in DONE, then rejected write in LOAD
    bus.Index   = 4'd5;
    bus.WrEn    = 1'b1;
    bus.WrIndex = 4'd5;
    bus.WrData  = 11'd7;
    #1;
    chk("wr_old", 32'(bus.Out), 32'd105);
    tick();
    bus.WrEn = 1'b0;
    #1;
    chk("wr_new", 32'(bus.Out), 32'd7);
    chk("wr_noerr", 32'(bus.WrErr), 32'd0);
    bus.Start = 1'b1;
    tick();
    bus.Start   = 1'b0;
    bus.WrEn    = 1'b1;
    bus.WrIndex = 4'd5;
    bus.WrData  = 11'd99;
    tick();
    bus.WrEn = 1'b0;
    chk("wrload_err", 32'(bus.WrErr), 32'd1);
    chk_entry("wrload_keep", 5, 11'd7);
    tick();
    chk("wrload_err_once", 32'(bus.WrErr), 32'd0);

    // 5. Restart after 6 entries; the same-cycle handshake is dropped
    for (int i = 0; i < 6; i++) begin
      bus.LdValid = 1'b1;
      bus.LdData  = 11'(200 + i);
      tick();
    end
    chk_entry("rs_part5", 5, 11'd205);
    bus.Start   = 1'b1;
    bus.LdValid = 1'b1;
    bus.LdData  = 11'h3FF;
    tick();
    bus.Start = 1'b0;
    chk_entry("rs_drop6", 6, 11'd106);
    bus.LdData = 11'd300;
    tick();
    chk_entry("rs_first0", 0, 11'd300);
    chk_entry("rs_keep1", 1, 11'd201);
    for (int i = 1; i < 16; i++) begin
      bus.LdData = 11'(300 + i);
      tick();
      if (i == 14) chk("rs_loaded_early", 32'(bus.Loaded), 32'd0);
    end
    bus.LdValid = 1'b0;
    chk("rs_loaded", 32'(bus.Loaded), 32'd1);
    chk_entry("rs_out15", 15, 11'd315);
    chk_entry("rs_out6", 6, 11'd306);

    // WrEn in the Start cycle is rejected
    bus.Start   = 1'b1;
    bus.WrEn    = 1'b1;
    bus.WrIndex = 4'd3;
    bus.WrData  = 11'd55;
    tick();
    bus.Start = 1'b0;
    bus.WrEn  = 1'b0;
    chk("wrstart_err", 32'(bus.WrErr), 32'd1);
    chk_entry("wrstart_keep", 3, 11'd303);

    // 6. Asynchronous reset between edges mid-load
    for (int i = 0; i < 3; i++) begin
      bus.LdValid = 1'b1;
      bus.LdData  = 11'(400 + i);
      tick();
    end
    bus.LdValid = 1'b0;
    bus.Index   = 4'd0;
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.Busy), 32'd0);
    chk("arst_ldready", 32'(bus.LdReady), 32'd0);
    chk("arst_out0", 32'(bus.Out), 32'd1);
    tick();
    Reset_n = 1'b1;
    tick();
    chk("arst_loaded", 32'(bus.Loaded), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk_entry($sformatf("arst_entry%0d", i), i, 11'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/target_lut_writer.md
Name: target_lut_writer

Overview:
- Programmable replacement for the fixed PC-target / data-address lookup table. It is the writer side of the same Index->Out lookup interface.
- After reset it holds a default table. On Start it accepts a stream of 16 signed 11-bit entries over a valid/ready load port, then serves lookups to the fetch/branch logic.
- A single-entry runtime write port allows patching individual entries outside a load.

Parameters:
- IDX_W, 4, index width; table depth is 2**IDX_W.
- DATA_W, 11, entry width, signed two's-complement offset.
- DEF_VAL, 1, reset value of every entry (fall-through +1).

Ports:
- Clk  input  1  single system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse; begins (or restarts) a full-table load.
- LdValid  input  1  load data valid.
- LdData  input  DATA_W  load entry, written in index order 0..15.
- LdReady  output  1  block can accept a load entry this cycle.
- WrEn  input  1  single-entry write request.
- WrIndex  input  IDX_W  entry to write.
- WrData  input  DATA_W  value to write.
- WrErr  output  1  one-cycle pulse: WrEn was rejected.
- Index  input  IDX_W  lookup index.
- Out  output  DATA_W  table[Index], combinational read.
- Busy  output  1  load in progress.
- Loaded  output  1  full table load has completed since the last Start.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - all entries = DEF_VAL; state = IDLE; load counter = 0.
  - LdReady = 0, Busy = 0, Loaded = 0, WrErr = 0.
  - Out therefore reads DEF_VAL for any Index.
- States: IDLE, LOAD, DONE.
- IDLE:
  - LdReady = 0.
  - Start -> LOAD with counter cleared.
- LOAD:
  - LdReady = 1, Busy = 1.
  - Handshake = LdValid && LdReady. On a handshake, table[cnt] <= LdData and cnt <= cnt + 1.
  - The handshake at cnt = 15 writes entry 15 and moves to DONE on the same edge. The counter wraps to 0.
  - LdValid low means stall; there is no timeout.
  - Start while in LOAD restarts at cnt = 0. Entries already written keep their new values. Any handshake in that same cycle is ignored.
- DONE:
  - Loaded = 1 (sticky), Busy = 0, LdReady = 0.
  - Start -> LOAD and Loaded clears on that edge.
- Runtime write:
  - Accepted in IDLE or DONE: table[WrIndex] <= WrData on the next edge.
  - In LOAD, or in the cycle Start is asserted, WrEn is dropped and WrErr pulses high for exactly the following cycle.
- Read-during-write:
  - Out is purely combinational from the registered table.
  - A write to the index currently being looked up shows the old value in the write cycle and the new value from the next cycle. There is no bypass.
- LdValid outside LOAD is ignored. LdData is don't-care when there is no handshake.
- Arithmetic: the counter is IDX_W bits and wraps naturally. Entries are stored as raw DATA_W bits with no sign extension inside the block; the consumer sign-extends.
- Reset mid-load: everything returns to reset values immediately and any partial load is lost.

Decomposition:
- Shared package:
  - lut_state_t enum {IDLE, LOAD, DONE}.
  - IDX_W and DATA_W defaults.
  - DEF_VAL constant.
- One natural sub-module: lut_regfile. It provides 2**IDX_W x DATA_W registers, one synchronous write port, one combinational read port, and async reset to DEF_VAL.
- The FSM, counter and write arbitration live in the top.

Test Plan:
1. Reset release, Index = 0 and 15 -> Out = 1, Loaded = 0, LdReady = 0.
2. Start, then 16 back-to-back handshakes with LdData = -370, 2, 3, ... 15, -357 -> Loaded high the cycle after the 16th handshake; Index = 0 gives 0x68E (-370); Index = 15 gives -357.
3. Load with LdValid toggled every other cycle -> exactly 16 entries written in order; Busy held the whole time; no entry skipped or duplicated.
4. In DONE: WrEn, WrIndex = 5, WrData = 7 with Index = 5 -> old value in the write cycle, 7 next cycle. Repeat during LOAD -> WrErr pulses once and entry 5 is unchanged.
5. Start mid-load after 6 entries -> counter restarts at 0. The next handshake writes entry 0, and Loaded is asserted only after 16 more handshakes.
6. Reset_n asserted asynchronously mid-load (between clock edges) -> outputs drop immediately; all entries read 1 after release.
